// File: rtl/tdm_mux_8x1.sv
// tdm_mux_8x1 -- 8-to-1 time-division multiplexer.
// A load captures eight channel bits into a shadow register. The bits are then
// serialized in ascending slot order, and each slot is held for HOLD cycles.
// The slot index drives the select pins of a downstream 1x8 demux. Every
// output is a flop, so the next-cycle output values are decoded from the
// next-state values.
// Legal range for HOLD is 1..16 (4-bit hold counter).

module tdm_mux_8x1 #(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic in4,
  input  logic in5,
  input  logic in6,
  input  logic in7,
  input  logic load,
  output logic ready,
  output logic out,
  output logic sel2,
  output logic sel1,
  output logic sel0,
  output logic valid,
  output logic frame_done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] shadow_q, shadow_d;
  logic [2:0] slot_q, slot_d;
  logic [3:0] hold_q, hold_d;

  logic [7:0] in_bus;
  logic       accept;
  logic       last_hold;
  logic       last_slot;

  logic       out_d;
  logic       valid_d;
  logic       frame_done_d;
  logic       ready_d;
  logic [2:0] sel_q, sel_d;

  assign in_bus    = {in7, in6, in5, in4, in3, in2, in1, in0};
  // ready is high only in IDLE or on the last frame cycle, so gating load
  // with it is the complete acceptance rule in both states.
  assign accept    = load & ready;
  assign last_hold = (hold_q == HOLD_LAST);
  assign last_slot = (slot_q == 3'd7);

  // Next-state logic: hold counter, slot advance, frame end / back-to-back reload.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    slot_d   = slot_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SEND;
          shadow_d = in_bus;
          slot_d   = 3'd0;
          hold_d   = 4'd0;
        end
      end
      SEND: begin
        if (!last_hold) begin
          hold_d = hold_q + 4'd1;
        end else if (!last_slot) begin
          slot_d = slot_q + 3'd1;
          hold_d = 4'd0;
        end else if (accept) begin
          shadow_d = in_bus;
          slot_d   = 3'd0;
          hold_d   = 4'd0;
        end else begin
          state_d = IDLE;
          slot_d  = 3'd0;
          hold_d  = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = 3'd0;
        hold_d  = 4'd0;
      end
    endcase
  end

  // Output decode from next-state values, so the registered outputs line up with the state.
  always_comb begin
    valid_d      = (state_d == SEND);
    sel_d        = valid_d ? slot_d : 3'd0;
    out_d        = valid_d & shadow_d[slot_d];
    frame_done_d = valid_d && (slot_d == 3'd7) && (hold_d == HOLD_LAST);
    ready_d      = !valid_d || frame_done_d;
  end

  // State register; reset aborts any frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= 8'd0;
      slot_q   <= 3'd0;
      hold_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      slot_q   <= slot_d;
      hold_q   <= hold_d;
    end
  end

  // Output registers; the reset values present an idle, ready interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out        <= 1'b0;
      sel_q      <= 3'd0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      ready      <= 1'b1;
    end else begin
      out        <= out_d;
      sel_q      <= sel_d;
      valid      <= valid_d;
      frame_done <= frame_done_d;
      ready      <= ready_d;
    end
  end

  assign sel2 = sel_q[2];
  assign sel1 = sel_q[1];
  assign sel0 = sel_q[0];

endmodule
